// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and the Gray-to-binary helper
// for the shared conversion block.
package gray_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_N_REQ = 4;
  localparam int MAX_W     = 16;

  // Callers zero-extend, so bit i is the XOR of all bits at or above i.
  function automatic logic [MAX_W-1:0] gray2bin(
    input logic [MAX_W-1:0] g
  );
    logic [MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Request and response channels between
// requesters and the shared converter.
interface gray_conv_arbiter_if
  import gray_conv_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*WIDTH-1:0]   req_gray;
  logic [N_REQ-1:0]         req_ready;
  logic                     rsp_valid;
  logic [WIDTH-1:0]         rsp_bin;
  logic [$clog2(N_REQ)-1:0] rsp_id;
  logic                     rsp_ready;

  modport master (
    output req_valid, req_gray, rsp_ready,
    input  req_ready, rsp_valid, rsp_bin, rsp_id
  );

  modport slave (
    input  req_valid, req_gray, rsp_ready,
    output req_ready, rsp_valid, rsp_bin, rsp_id
  );
endinterface

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
// Round-robin arbiter: first set request at
// or after ptr, circular, one-hot grant.
module rr_arbiter
  import gray_conv_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant
);
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % N_REQ);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/gray_conv_arbiter.sv
// One Gray-to-binary datapath shared by N_REQ
// requesters through a round-robin grant.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_conv_arbiter_if.slave  bus,
  output logic                busy,
  output logic [CNT_W-1:0]    done_count
);
  localparam int IDW = $clog2(N_REQ);

  state_t           r_state;
  state_t           w_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_rsp_id;
  logic [IDW-1:0]   w_gid;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] r_rsp_bin;
  logic [WIDTH-1:0] w_gsel;
  logic             r_rsp_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] w_grant;
  logic             w_idle;
  logic             w_take;

  assign w_idle = (r_state == IDLE);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_en    (rst_n),
    .o_grant (w_grant)
  );

  assign bus.req_ready = w_grant & {N_REQ{w_idle}};
  assign w_take        = |bus.req_ready;

  always_comb begin
    w_gid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_gid = IDW'(i);
    end
  end

  always_comb begin
    int base;
    base   = int'(w_gid) * WIDTH;
    w_gsel = bus.req_gray[base +: WIDTH];
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_take) w_nxt = CONV;
      CONV:    w_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_gray      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_bin   <= '0;
      r_rsp_id    <= '0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_take) begin
        r_gray <= w_gsel;
        r_id   <= w_gid;
      end
      if (r_state == CONV) begin
        r_rsp_bin   <= WIDTH'(gray2bin(MAX_W'(r_gray)));
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end
      if (r_state == RESP && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_ptr <= (r_rsp_id == IDW'(N_REQ - 1))
               ? '0 : r_rsp_id + 1'b1;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_bin   = r_rsp_bin;
  assign bus.rsp_id    = r_rsp_id;
  assign busy          = !w_idle;
  assign done_count    = r_cnt;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed-vector bench for gray_conv_arbiter,
// with a CNT_W=2 twin for counter saturation.
module tb_gray_conv_arbiter;
  import gray_conv_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       busy_m;
  logic       busy_s;
  logic [7:0] done_m;
  logic [1:0] done_s;

  int n_vec;
  int n_err;

  gray_conv_arbiter_if #(.N_REQ(4), .WIDTH(4)) ifm ();
  gray_conv_arbiter_if #(.N_REQ(4), .WIDTH(4)) ifs ();

  assign ifs.req_valid = ifm.req_valid;
  assign ifs.req_gray  = ifm.req_gray;
  assign ifs.rsp_ready = ifm.rsp_ready;

  gray_conv_arbiter #(.N_REQ(4), .WIDTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifm),
    .busy       (busy_m),
    .done_count (done_m)
  );

  gray_conv_arbiter #(.N_REQ(4), .WIDTH(4), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifs),
    .busy       (busy_s),
    .done_count (done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  logic [3:0] rr_bin [5];
  logic [1:0] rr_id  [5];
  logic [1:0] sat_exp [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    rr_bin = '{4'b0001, 4'b1111, 4'b1001, 4'b0000, 4'b0001};
    rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // reset with every requester asking
    rst_n         = 1'b0;
    ifm.req_valid = 4'b1111;
    ifm.req_gray  = 16'h0000;
    ifm.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(ifm.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(ifm.rsp_valid), 32'h0);
    chk("rst_done",      32'(done_m),        32'h0);
    chk("rst_busy",      32'(busy_m),        32'h0);
    rst_n = 1'b1;
    #1;
    chk("first_grant",   32'(ifm.req_ready), 32'h1);

    // single request from requester 2
    ifm.req_valid = 4'b0000;
    do_reset();
    ifm.req_valid = 4'b0100;
    ifm.req_gray  = 16'h0600;
    ifm.rsp_ready = 1'b1;
    #1;
    chk("single_ready", 32'(ifm.req_ready), 32'h4);
    tick();
    ifm.req_valid = 4'b0000;
    chk("single_busy",  32'(busy_m),        32'h1);
    chk("single_vld_t1",32'(ifm.rsp_valid), 32'h0);
    tick();
    chk("single_vld",   32'(ifm.rsp_valid), 32'h1);
    chk("single_bin",   32'(ifm.rsp_bin),   32'h4);
    chk("single_id",    32'(ifm.rsp_id),    32'h2);
    tick();
    chk("single_done",  32'(done_m),        32'h1);
    chk("single_drop",  32'(ifm.rsp_valid), 32'h0);

    // round robin over all four
    do_reset();
    ifm.req_valid = 4'b1111;
    ifm.req_gray  = 16'h0D81;
    ifm.rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 32'(ifm.req_ready), 32'(4'b0001 << rr_id[k]));
      tick();
      chk("rr_busy",  32'(busy_m),        32'h1);
      tick();
      chk("rr_vld",   32'(ifm.rsp_valid), 32'h1);
      chk("rr_bin",   32'(ifm.rsp_bin),   32'(rr_bin[k]));
      chk("rr_id",    32'(ifm.rsp_id),    32'(rr_id[k]));
      tick();
      chk("rr_done",  32'(done_m),        32'(k + 1));
    end

    // backpressure in RESP
    ifm.req_valid = 4'b0000;
    do_reset();
    ifm.req_valid = 4'b0010;
    ifm.req_gray  = 16'h00A0;
    ifm.rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(ifm.req_ready), 32'h2);
    tick();
    ifm.req_valid = 4'b1111;
    ifm.req_gray  = 16'hFFFF;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_vld",   32'(ifm.rsp_valid), 32'h1);
      chk("bp_bin",   32'(ifm.rsp_bin),   32'hC);
      chk("bp_id",    32'(ifm.rsp_id),    32'h1);
      chk("bp_ready", 32'(ifm.req_ready), 32'h0);
      tick();
    end
    ifm.rsp_ready = 1'b1;
    #1;
    chk("bp_nogrant", 32'(ifm.req_ready), 32'h0);
    tick();
    chk("bp_drop",  32'(ifm.rsp_valid), 32'h0);
    chk("bp_idle",  32'(busy_m),        32'h0);
    chk("bp_done",  32'(done_m),        32'h1);
    chk("bp_next",  32'(ifm.req_ready), 32'h4);
    ifm.req_valid = 4'b0000;

    // reset while in CONV
    do_reset();
    ifm.req_valid = 4'b0100;
    ifm.req_gray  = 16'h0300;
    ifm.rsp_ready = 1'b1;
    tick();
    ifm.req_valid = 4'b0000;
    tick();
    tick();
    ifm.req_valid = 4'b0001;
    ifm.req_gray  = 16'h0003;
    tick();
    ifm.req_valid = 4'b0000;
    chk("mid_busy",  32'(busy_m), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_vld",   32'(ifm.rsp_valid), 32'h0);
    chk("mid_idle",  32'(busy_m),        32'h0);
    chk("mid_done",  32'(done_m),        32'h0);
    tick();
    tick();
    chk("mid_norsp", 32'(ifm.rsp_valid), 32'h0);
    ifm.req_valid = 4'b1111;
    #1;
    chk("mid_ptr0",  32'(ifm.req_ready), 32'h1);
    ifm.req_valid = 4'b0000;

    // counter saturation on the CNT_W=2 twin
    do_reset();
    ifm.req_valid = 4'b0001;
    ifm.req_gray  = 16'h0005;
    ifm.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      tick();
      chk("sat_done2", 32'(done_s), 32'(sat_exp[k]));
      chk("sat_done8", 32'(done_m), 32'(k + 1));
    end
    ifm.req_valid = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
